// File: rtl/dmac_controller_if.sv
// Control and config-fetch bus signals between the DMAC controller, datapath and AHB master port.
interface dmac_controller_if;
   logic [1:0] DmacReq;
   logic       HReady;
   logic [1:0] M_HResp;
   logic       C_config;
   logic       irq;
   logic       DmacReq_Reg_en;
   logic       PeriAddr_reg_en;
   logic       SAddr_Reg_en;
   logic       DAddr_Reg_en;
   logic       Trans_sz_Reg_en;
   logic       Ctrl_Reg_en;
   logic [1:0] addr_inc_sel;
   logic [1:0] config_HTrans;
   logic       config_write;
   logic [1:0] con_sel;
   logic       con_en;
   logic       channel_en_1;
   logic       channel_en_2;
   logic       busy;
   logic       err;

   modport master (
      input  DmacReq, HReady, M_HResp, C_config, irq,
      output DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en,
             Ctrl_Reg_en, addr_inc_sel, config_HTrans, config_write, con_sel, con_en,
             channel_en_1, channel_en_2, busy, err
   );

   modport slave (
      output DmacReq, HReady, M_HResp, C_config, irq,
      input  DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en,
             Ctrl_Reg_en, addr_inc_sel, config_HTrans, config_write, con_sel, con_en,
             channel_en_1, channel_en_2, busy, err
   );
endinterface

// File: rtl/dmac_controller.sv
// Two-channel DMAC control FSM: grant, 4-word AHB config fetch, channel enable until irq.
// Optional DMAC_RR_ARB_EN: a simultaneous request alternates against the last completed grant.
module dmac_controller (
   input logic               clk,
   input logic               rst_n,
   dmac_controller_if.master bus
);
   localparam int unsigned CFG_WORDS = 4;
   localparam logic [2:0]  LastBeat  = 3'(CFG_WORDS);

   typedef enum logic [2:0] {StIdle, StLatch, StCfg, StCheck, StXfer, StDone, StAbort} state_e;

   state_e     state_q, state_d;
   logic [2:0] beat_q, beat_d;
   logic       gnt_q, gnt_d;   // 0 = channel 1, 1 = channel 2
   logic       arb_gnt;
   logic       bus_err;

   assign bus_err = (bus.M_HResp == 2'b01);

`ifdef DMAC_RR_ARB_EN
   logic last_gnt_q;

   // Reset to channel 2 so the first simultaneous request goes to channel 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
      end else if (state_q == StDone) begin
         last_gnt_q <= gnt_q;
      end
   end

   assign arb_gnt = (bus.DmacReq == 2'b11) ? ~last_gnt_q : ~bus.DmacReq[0];
`else
   assign arb_gnt = ~bus.DmacReq[0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         beat_q  <= 3'd0;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.DmacReq != 2'b00) begin
               state_d = StLatch;
               gnt_d   = arb_gnt;
            end
         end
         StLatch: begin
            state_d = StCfg;
            beat_d  = 3'd0;
         end
         StCfg: begin
            if (bus_err) begin
               state_d = StAbort;
               beat_d  = 3'd0;
            end else if (bus.HReady) begin
               if (beat_q == LastBeat) begin
                  state_d = StCheck;
                  beat_d  = 3'd0;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         StCheck: state_d = bus.C_config ? StXfer : StAbort;
         StXfer:  if (bus.irq) state_d = StDone;
         StDone:  state_d = StIdle;
         StAbort: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.DmacReq_Reg_en  = 1'b0;
      bus.PeriAddr_reg_en = 1'b0;
      bus.SAddr_Reg_en    = 1'b0;
      bus.DAddr_Reg_en    = 1'b0;
      bus.Trans_sz_Reg_en = 1'b0;
      bus.Ctrl_Reg_en     = 1'b0;
      bus.addr_inc_sel    = 2'b00;
      bus.config_HTrans   = 2'b00;
      bus.config_write    = 1'b0;
      bus.con_sel         = 2'b10;
      bus.con_en          = 1'b0;
      bus.channel_en_1    = 1'b0;
      bus.channel_en_2    = 1'b0;
      bus.busy            = (state_q != StIdle);
      bus.err             = 1'b0;
      unique case (state_q)
         StLatch: begin
            bus.DmacReq_Reg_en  = 1'b1;
            bus.PeriAddr_reg_en = 1'b1;
            bus.con_en          = 1'b1;
         end
         StCfg: begin
            bus.addr_inc_sel = beat_q[1:0];
            if (beat_q == 3'd0) begin
               bus.config_HTrans = 2'b10;
            end else if (beat_q != LastBeat) begin
               bus.config_HTrans = 2'b11;
            end
            // Data phase of beat k-1 completes in beat k.
            if (bus.HReady && !bus_err) begin
               case (beat_q)
                  3'd1:    bus.SAddr_Reg_en    = 1'b1;
                  3'd2:    bus.DAddr_Reg_en    = 1'b1;
                  3'd3:    bus.Trans_sz_Reg_en = 1'b1;
                  3'd4:    bus.Ctrl_Reg_en     = 1'b1;
                  default: ;
               endcase
            end
         end
         StCheck: begin
            if (bus.C_config) begin
               bus.con_sel = {1'b0, gnt_q};
               bus.con_en  = 1'b1;
            end
         end
         StXfer: begin
            bus.con_sel      = {1'b0, gnt_q};
            bus.channel_en_1 = ~gnt_q;
            bus.channel_en_2 = gnt_q;
         end
         StDone:  bus.con_en = 1'b1;
         StAbort: bus.err    = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dmac_controller.sv
// Directed bench for dmac_controller: fetch sequencing, wait states, aborts, arbitration, reset.
module tb_dmac_controller;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   dmac_controller_if bus ();

   dmac_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.DmacReq  = 2'b00;
      bus.HReady   = 1'b1;
      bus.M_HResp  = 2'b00;
      bus.C_config = 1'b1;
      bus.irq      = 1'b0;
   endtask

   // Leaves the bench at the start of the CHECK cycle (cycle 7) with zero wait states.
   task automatic start_and_fetch(input logic [1:0] req);
      bus.DmacReq = req;
      next_cycle();
      bus.DmacReq = 2'b00;
      repeat (6) next_cycle();
   endtask

   task automatic finish_xfer();
      bus.irq = 1'b1;
      next_cycle();
      bus.irq = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset();
      logic [3:0] en;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      en = {bus.SAddr_Reg_en, bus.DAddr_Reg_en, bus.Trans_sz_Reg_en, bus.Ctrl_Reg_en};
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
      total++; if (bus.con_sel !== 2'b10) begin bad++; $display("FAIL rst_con_sel got=%b want=10", bus.con_sel); end
      total++; if (bus.config_HTrans !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%b want=00", bus.config_HTrans); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
      total++; if ({bus.channel_en_1, bus.channel_en_2, en} !== 6'b0) begin
         bad++; $display("FAIL rst_enables got=%b want=000000", {bus.channel_en_1, bus.channel_en_2, en});
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_basic();
      logic [1:0] htr_exp [5];
      logic [3:0] en_exp [5];
      logic [3:0] en;
      logic [1:0] kk;
      htr_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
      en_exp  = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      bus.DmacReq = 2'b01;
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_c0_busy got=%b want=0", bus.busy); end
      next_cycle();
      bus.DmacReq = 2'b00;
      #1;
      total++; if ({bus.DmacReq_Reg_en, bus.PeriAddr_reg_en, bus.con_en, bus.busy} !== 4'b1111) begin
         bad++; $display("FAIL basic_latch got=%b want=1111",
                         {bus.DmacReq_Reg_en, bus.PeriAddr_reg_en, bus.con_en, bus.busy});
      end
      total++; if (bus.con_sel !== 2'b10) begin bad++; $display("FAIL basic_latch_sel got=%b want=10", bus.con_sel); end
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         #1;
         kk = 2'(k);
         en = {bus.SAddr_Reg_en, bus.DAddr_Reg_en, bus.Trans_sz_Reg_en, bus.Ctrl_Reg_en};
         if (k < 4) begin
            total++; if (bus.addr_inc_sel !== kk) begin
               bad++; $display("FAIL basic_addr k=%0d got=%0d want=%0d", k, bus.addr_inc_sel, kk);
            end
         end
         total++; if (bus.config_HTrans !== htr_exp[k]) begin
            bad++; $display("FAIL basic_htrans k=%0d got=%b want=%b", k, bus.config_HTrans, htr_exp[k]);
         end
         total++; if (en !== en_exp[k]) begin
            bad++; $display("FAIL basic_en k=%0d got=%b want=%b", k, en, en_exp[k]);
         end
         total++; if (bus.config_write !== 1'b0) begin bad++; $display("FAIL basic_write got=%b want=0", bus.config_write); end
      end
      next_cycle();
      #1;
      total++; if ({bus.con_sel, bus.con_en, bus.channel_en_1} !== 4'b0010) begin
         bad++; $display("FAIL basic_check got=%b want=0010", {bus.con_sel, bus.con_en, bus.channel_en_1});
      end
      next_cycle();
      #1;
      total++; if ({bus.channel_en_1, bus.channel_en_2, bus.con_sel} !== 4'b1000) begin
         bad++; $display("FAIL basic_c8_xfer got=%b want=1000", {bus.channel_en_1, bus.channel_en_2, bus.con_sel});
      end
      bus.irq = 1'b1;
      next_cycle();
      bus.irq = 1'b0;
      #1;
      total++; if ({bus.channel_en_1, bus.con_en, bus.con_sel, bus.busy} !== 5'b01101) begin
         bad++; $display("FAIL basic_done got=%b want=01101",
                         {bus.channel_en_1, bus.con_en, bus.con_sel, bus.busy});
      end
      next_cycle();
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", bus.busy); end
   endtask

   task automatic test_wait_states();
      logic [3:0] en;
      bus.DmacReq = 2'b01;
      next_cycle();
      bus.DmacReq = 2'b00;
      repeat (3) next_cycle();
      bus.HReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         en = {bus.SAddr_Reg_en, bus.DAddr_Reg_en, bus.Trans_sz_Reg_en, bus.Ctrl_Reg_en};
         total++; if (bus.addr_inc_sel !== 2'd2) begin
            bad++; $display("FAIL ws_addr i=%0d got=%0d want=2", i, bus.addr_inc_sel);
         end
         total++; if (en !== 4'b0000) begin bad++; $display("FAIL ws_stall_en i=%0d got=%b want=0000", i, en); end
         next_cycle();
      end
      bus.HReady = 1'b1;
      #1;
      total++; if ({bus.addr_inc_sel, bus.DAddr_Reg_en} !== 3'b101) begin
         bad++; $display("FAIL ws_resume got=%b want=101", {bus.addr_inc_sel, bus.DAddr_Reg_en});
      end
      repeat (4) next_cycle();
      #1;
      total++; if (bus.channel_en_1 !== 1'b1) begin bad++; $display("FAIL ws_xfer got=%b want=1", bus.channel_en_1); end
      finish_xfer();
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ws_idle got=%b want=0", bus.busy); end
   endtask

   task automatic test_bus_error();
      logic seen_late_en;
      seen_late_en = 1'b0;
      bus.DmacReq = 2'b01;
      next_cycle();
      bus.DmacReq = 2'b00;
      repeat (4) next_cycle();
      bus.M_HResp = 2'b01;
      #1;
      seen_late_en = seen_late_en | bus.Trans_sz_Reg_en | bus.Ctrl_Reg_en;
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL berr_c5_err got=%b want=0", bus.err); end
      next_cycle();
      bus.M_HResp = 2'b00;
      #1;
      seen_late_en = seen_late_en | bus.Trans_sz_Reg_en | bus.Ctrl_Reg_en;
      total++; if ({bus.err, bus.busy, bus.channel_en_1} !== 3'b110) begin
         bad++; $display("FAIL berr_abort got=%b want=110", {bus.err, bus.busy, bus.channel_en_1});
      end
      next_cycle();
      #1;
      seen_late_en = seen_late_en | bus.Trans_sz_Reg_en | bus.Ctrl_Reg_en;
      total++; if ({bus.err, bus.busy, bus.channel_en_1} !== 3'b000) begin
         bad++; $display("FAIL berr_idle got=%b want=000", {bus.err, bus.busy, bus.channel_en_1});
      end
      total++; if (seen_late_en !== 1'b0) begin bad++; $display("FAIL berr_late_en got=%b want=0", seen_late_en); end
   endtask

   task automatic test_config_invalid();
      bus.C_config = 1'b0;
      start_and_fetch(2'b10);
      #1;
      total++; if ({bus.channel_en_1, bus.channel_en_2, bus.err} !== 3'b000) begin
         bad++; $display("FAIL cfg0_check got=%b want=000", {bus.channel_en_1, bus.channel_en_2, bus.err});
      end
      next_cycle();
      #1;
      total++; if ({bus.err, bus.channel_en_2} !== 2'b10) begin
         bad++; $display("FAIL cfg0_abort got=%b want=10", {bus.err, bus.channel_en_2});
      end
      next_cycle();
      #1;
      total++; if ({bus.busy, bus.err, bus.channel_en_2} !== 3'b000) begin
         bad++; $display("FAIL cfg0_idle got=%b want=000", {bus.busy, bus.err, bus.channel_en_2});
      end
      bus.C_config = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [1:0] sel2;
      logic [1:0] ch2;
`ifdef DMAC_RR_ARB_EN
      sel2 = 2'b01;
      ch2  = 2'b01;
`else
      sel2 = 2'b00;
      ch2  = 2'b10;
`endif
      start_and_fetch(2'b11);
      #1;
      total++; if (bus.con_sel !== 2'b00) begin bad++; $display("FAIL b2b_sel1 got=%b want=00", bus.con_sel); end
      next_cycle();
      #1;
      total++; if ({bus.channel_en_1, bus.channel_en_2} !== 2'b10) begin
         bad++; $display("FAIL b2b_ch1 got=%b want=10", {bus.channel_en_1, bus.channel_en_2});
      end
      bus.DmacReq = 2'b11;
      finish_xfer();
      start_and_fetch(2'b11);
      #1;
      total++; if (bus.con_sel !== sel2) begin bad++; $display("FAIL b2b_sel2 got=%b want=%b", bus.con_sel, sel2); end
      next_cycle();
      #1;
      total++; if ({bus.channel_en_1, bus.channel_en_2} !== ch2) begin
         bad++; $display("FAIL b2b_ch2 got=%b want=%b", {bus.channel_en_1, bus.channel_en_2}, ch2);
      end
      finish_xfer();
   endtask

   task automatic test_reset_mid_xfer();
      start_and_fetch(2'b01);
      next_cycle();
      #1;
      total++; if (bus.channel_en_1 !== 1'b1) begin bad++; $display("FAIL rstx_pre got=%b want=1", bus.channel_en_1); end
      rst_n = 1'b0;
      #1;
      total++; if ({bus.channel_en_1, bus.busy, bus.con_sel} !== 4'b0010) begin
         bad++; $display("FAIL rstx_drop got=%b want=0010", {bus.channel_en_1, bus.busy, bus.con_sel});
      end
      #1;
      rst_n = 1'b1;
      next_cycle();
      #1;
      total++; if ({bus.busy, bus.channel_en_1} !== 2'b00) begin
         bad++; $display("FAIL rstx_after got=%b want=00", {bus.busy, bus.channel_en_1});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_wait_states();
      test_bus_error();
      test_config_invalid();
      test_back_to_back();
      test_reset_mid_xfer();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
